obj_loader: RTL and testbench
=============================

OBJ_LOADER -- requirements
Module: obj_loader

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, meaning high byte of each word arrives first (0: low byte first).
REQ-002 SHALL have port clk  input  1  system clock; drives the memory external port clock (clkExt) at top level.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin one load; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of the current load.
REQ-006 SHALL have port byteIn  input  8  incoming object-stream byte.
REQ-007 SHALL have port byteValid  input  1  byteIn valid.
REQ-008 SHALL have port byteReady  output  1  loader accepts byteIn this cycle.
REQ-009 SHALL have port memAddrExt  output  16  external-port write address.
REQ-010 SHALL have port memDataExt  output  16  external-port write data.
REQ-011 SHALL have port memWEExt  output  1  external-port write enable.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-014 SHALL have port wordCount  output  16  data words written in the current or last load.

Function
REQ-015 Stream format SHALL be: origin word, length word N, then N data words; each word two bytes, order per BIG_ENDIAN.
REQ-016 A byte SHALL transfer only on a clk edge where byteValid=1 and byteReady=1.
REQ-017 States SHALL be IDLE, ORIG_H, ORIG_L, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, DONE.
REQ-018 byteReady SHALL be 1 only in ORIG_H, ORIG_L, LEN_H, LEN_L, DATA_H, DATA_L; 0 in IDLE, WRITE, DONE.
REQ-019 IDLE with start=1 SHALL go to ORIG_H, set busy=1, clear wordCount to 0; start in any other state SHALL be ignored.
REQ-020 Each *_H state SHALL advance to its *_L state on a byte transfer; no transfer SHALL hold the state.
REQ-021 ORIG_L transfer SHALL load the assembled origin into memAddrExt and go to LEN_H.
REQ-022 LEN_L transfer SHALL load the remaining count N; N=0 SHALL go directly to DONE, else to DATA_H.
REQ-023 DATA_L transfer SHALL place the assembled word on memDataExt and go to WRITE.
REQ-024 WRITE SHALL last exactly one cycle with memWEExt=1 and memAddrExt/memDataExt stable for that cycle.
REQ-025 On leaving WRITE: memAddrExt SHALL increment modulo 2^16 (0xFFFF wraps to 0x0000), wordCount SHALL increment, remaining count SHALL decrement; remaining 0 goes to DONE, else DATA_H.
REQ-026 memWEExt SHALL be 0 in every state other than WRITE.
REQ-027 Peak throughput SHALL be one word per 3 cycles (DATA_H, DATA_L, WRITE).
REQ-028 DONE SHALL last one cycle with done=1, busy=0 thereafter, then return to IDLE; wordCount SHALL hold until next start.
REQ-029 abort=1 in any non-IDLE state SHALL return to IDLE next edge with memWEExt=0, busy=0, no done pulse; writes already completed SHALL remain; abort SHALL take priority over a simultaneous byte transfer or WRITE.
REQ-030 busy SHALL be 1 from the edge leaving IDLE until the edge entering DONE or IDLE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, memWEExt=0, byteReady=0, busy=0, done=0, memAddrExt=0x0000, memDataExt=0x0000, wordCount=0x0000, independent of clk.
REQ-032 rst asserted mid-WRITE SHALL drop memWEExt within the same cycle; no partial load SHALL resume after rst deasserts.

Verification
REQ-033 BIG_ENDIAN=1, bytes 30 00 00 02 12 34 AB CD, byteValid held 1 -> writes 0x1234@0x3000, 0xABCD@0x3001, wordCount=2, single done pulse, 3 cycles between memWEExt pulses.
REQ-034 Origin 0xFFFF, N=2, data 0x0001 0x0002 -> writes 0x0001@0xFFFF, 0x0002@0x0000 (wrap).
REQ-035 Origin 0x3000, N=0 -> no memWEExt pulse, done pulses, wordCount=0.
REQ-036 byteValid gaps of 0-5 cycles inserted randomly between bytes -> identical writes to REQ-033, state held during gaps, byteReady=0 during WRITE.
REQ-037 abort during second DATA_L of N=3 load -> exactly one write performed, busy=0 next cycle, no done pulse; following start loads correctly.
REQ-038 rst asserted asynchronously mid-load (between edges, during WRITE) -> memWEExt, busy, byteReady fall without clk edge; all outputs at REQ-031 values.

Source files
------------

// File: rtl/obj_loader.sv
// Object-stream loader: parses origin, length and data words from a byte
// stream and writes the data words to consecutive external memory addresses.
module obj_loader #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [15:0] memAddrExt,
  output logic [15:0] memDataExt,
  output logic        memWEExt,
  output logic        busy,
  output logic        done,
  output logic [15:0] wordCount
);

  typedef enum logic [3:0] {
    IDLE, ORIG_H, ORIG_L, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, DONE
  } state_t;

  state_t      state, nextState;
  logic [7:0]  firstByte;
  logic [15:0] remaining;
  logic [15:0] assembled;
  logic        xfer;

  assign xfer      = byteValid && byteReady;
  assign assembled = BIG_ENDIAN ? {firstByte, byteIn} : {byteIn, firstByte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (abort && state != IDLE) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) nextState = ORIG_H;
        ORIG_H:  if (xfer)  nextState = ORIG_L;
        ORIG_L:  if (xfer)  nextState = LEN_H;
        LEN_H:   if (xfer)  nextState = LEN_L;
        LEN_L:   if (xfer)  nextState = (assembled == 16'h0000) ? DONE : DATA_H;
        DATA_H:  if (xfer)  nextState = DATA_L;
        DATA_L:  if (xfer)  nextState = WRITE;
        WRITE:   nextState = (remaining == 16'h0001) ? DONE : DATA_H;
        DONE:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Outputs decode from state alone so an async reset drops them at once;
  // abort masks ready/write-enable so it wins over a same-cycle transfer.
  always_comb begin
    byteReady = 1'b0;
    memWEExt  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ORIG_H, ORIG_L, LEN_H, LEN_L, DATA_H, DATA_L: begin
        byteReady = !abort;
        busy      = 1'b1;
      end
      WRITE: begin
        memWEExt = !abort;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      firstByte  <= '0;
      remaining  <= '0;
      memAddrExt <= '0;
      memDataExt <= '0;
      wordCount  <= '0;
    end else begin
      case (state)
        IDLE: if (start) wordCount <= '0;
        ORIG_H, LEN_H, DATA_H: if (xfer) firstByte <= byteIn;
        ORIG_L: if (xfer) memAddrExt <= assembled;
        LEN_L:  if (xfer) remaining  <= assembled;
        DATA_L: if (xfer) memDataExt <= assembled;
        WRITE: if (!abort) begin
          memAddrExt <= memAddrExt + 16'd1;
          wordCount  <= wordCount + 16'd1;
          remaining  <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_loader.sv
// Directed bench for obj_loader: normal load, address wrap, empty load,
// byteValid gaps, abort and asynchronous reset mid-write.
module tb_obj_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  byteIn = '0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [15:0] memAddrExt, memDataExt, wordCount;
  logic        memWEExt, busy, done;

  int nAssert = 0;
  int nFail = 0;
  int cyc = 0;
  int doneCnt = 0;
  int rdyInWrite = 0;
  logic [15:0] wrAddr[$];
  logic [15:0] wrData[$];
  int          wrCyc[$];

  obj_loader #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .memAddrExt(memAddrExt), .memDataExt(memDataExt), .memWEExt(memWEExt),
    .busy(busy), .done(done), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (memWEExt) begin
      wrAddr.push_back(memAddrExt);
      wrData.push_back(memDataExt);
      wrCyc.push_back(cyc);
      if (byteReady) rdyInWrite++;
    end
    if (done) doneCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete(); wrData.delete(); wrCyc.delete();
    doneCnt = 0; rdyInWrite = 0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte after `gap` idle cycles; returns on the negedge after transfer.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    byteValid = 1'b0;
    repeat (gap) @(negedge clk);
    byteIn = b;
    byteValid = 1'b1;
    n = 0;
    while (!byteReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("byteReadyTimeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    byteValid = 1'b0;
  endtask

  task automatic sendStream(input logic [7:0] bytes[$], input int maxGap);
    foreach (bytes[i]) sendByte(bytes[i], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
  endtask

  task automatic checkLoad1(input string tag);
    chk({tag, "_nWrites"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      chk({tag, "_addr0"}, {16'h0, wrAddr[0]}, 32'h3000);
      chk({tag, "_data0"}, {16'h0, wrData[0]}, 32'h1234);
      chk({tag, "_addr1"}, {16'h0, wrAddr[1]}, 32'h3001);
      chk({tag, "_data1"}, {16'h0, wrData[1]}, 32'hABCD);
    end
    chk({tag, "_wordCount"}, {16'h0, wordCount}, 32'd2);
    chk({tag, "_doneCnt"}, 32'(doneCnt), 32'd1);
    chk({tag, "_busyAfter"}, {31'h0, busy}, 32'd0);
    chk({tag, "_rdyInWrite"}, 32'(rdyInWrite), 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_addr", {16'h0, memAddrExt}, 32'h0);
    chk("rst_data", {16'h0, memDataExt}, 32'h0);
    chk("rst_wc", {16'h0, wordCount}, 32'h0);
    chk("rst_ctl", {28'h0, memWEExt, byteReady, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic big-endian load, byteValid held high
    clearLog();
    pulseStart();
    chk("t1_busyStart", {31'h0, busy}, 32'd1);
    chk("t1_wcCleared", {16'h0, wordCount}, 32'd0);
    s = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    sendStream(s, 0);
    repeat (6) @(negedge clk);
    checkLoad1("t1");
    if (wrCyc.size() == 2) chk("t1_spacing", 32'(wrCyc[1] - wrCyc[0]), 32'd3);
    repeat (3) @(negedge clk);
    chk("t1_wcHold", {16'h0, wordCount}, 32'd2);
    chk("t1_doneOnce", 32'(doneCnt), 32'd1);

    // Address wrap past 0xFFFF
    clearLog();
    pulseStart();
    s = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
    sendStream(s, 0);
    repeat (6) @(negedge clk);
    chk("t2_nWrites", 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      chk("t2_addr0", {16'h0, wrAddr[0]}, 32'hFFFF);
      chk("t2_data0", {16'h0, wrData[0]}, 32'h0001);
      chk("t2_addr1", {16'h0, wrAddr[1]}, 32'h0000);
      chk("t2_data1", {16'h0, wrData[1]}, 32'h0002);
    end
    chk("t2_wc", {16'h0, wordCount}, 32'd2);

    // Empty load: N = 0
    clearLog();
    pulseStart();
    s = '{8'h30, 8'h00, 8'h00, 8'h00};
    sendStream(s, 0);
    repeat (4) @(negedge clk);
    chk("t3_nWrites", 32'(wrAddr.size()), 32'd0);
    chk("t3_doneCnt", 32'(doneCnt), 32'd1);
    chk("t3_wc", {16'h0, wordCount}, 32'd0);

    // Random byteValid gaps
    clearLog();
    pulseStart();
    s = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    sendStream(s, 5);
    repeat (6) @(negedge clk);
    checkLoad1("t4");

    // Abort during second DATA_L of an N=3 load, with a byte offered
    clearLog();
    pulseStart();
    s = '{8'h10, 8'h00, 8'h00, 8'h03, 8'hAA, 8'h01, 8'hBB};
    sendStream(s, 0);
    byteIn = 8'hCC;
    byteValid = 1'b1;
    abort = 1'b1;
    #1;
    chk("t5_rdyMasked", {31'h0, byteReady}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    byteValid = 1'b0;
    chk("t5_busy", {31'h0, busy}, 32'd0);
    chk("t5_we", {31'h0, memWEExt}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_nWrites", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() == 1) chk("t5_write0", {wrAddr[0], wrData[0]}, 32'h1000AA01);
    chk("t5_noDone", 32'(doneCnt), 32'd0);
    chk("t5_wc", {16'h0, wordCount}, 32'd1);
    chk("t5_idleRdy", {31'h0, byteReady}, 32'd0);

    clearLog();
    pulseStart();
    s = '{8'h20, 8'h00, 8'h00, 8'h01, 8'h55, 8'h55};
    sendStream(s, 0);
    repeat (5) @(negedge clk);
    chk("t6_nWrites", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() == 1) chk("t6_write0", {wrAddr[0], wrData[0]}, 32'h20005555);
    chk("t6_doneCnt", 32'(doneCnt), 32'd1);
    chk("t6_wc", {16'h0, wordCount}, 32'd1);

    // Asynchronous reset in the middle of WRITE
    clearLog();
    pulseStart();
    s = '{8'h40, 8'h00, 8'h00, 8'h02, 8'h99, 8'h99};
    sendStream(s, 0);
    chk("t7_inWrite", {31'h0, memWEExt}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_ctl", {28'h0, memWEExt, byteReady, busy, done}, 32'h0);
    chk("t7_addr", {16'h0, memAddrExt}, 32'h0);
    chk("t7_data", {16'h0, memDataExt}, 32'h0);
    chk("t7_wc", {16'h0, wordCount}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    byteIn = 8'h77;
    byteValid = 1'b1;
    repeat (5) @(negedge clk);
    byteValid = 1'b0;
    chk("t7_noResume", {30'h0, busy, byteReady}, 32'h0);
    chk("t7_nWrites", 32'(wrAddr.size()), 32'd1);
    chk("t7_noDone", 32'(doneCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
